aes_key_expander: RTL and testbench

- Iterative FIPS-197 §5.2 key expansion engine; produces one 32-bit schedule word w[i] per accepted output beat.
- Instantiates the SubWord stage (4 Sboxes, combinational) and feeds it RotWord(w[i-1]) or w[i-1].
- Sits between the key-load interface and the round-key store used by the decryption datapath, which consumes words in index order.

---
 rtl/aes_key_expander.sv | 184 ++++++++++++++++++
 tb/tb_aes_key_expander.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expander.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : aes_key_expander                                                |
// | Purpose  : Iterative AES key expansion. Emits the schedule words w[0..NW-1]|
// |            one per handshake beat, in index order, for AES-128/192/256.    |
// | Ports    : clk, rst_n (async active-low)                                   |
// |            key_in/key_valid/key_ready : cipher key load (word j at         |
// |                                         key_in[32*j +: 32])                |
// |            wk_out/wk_idx/wk_valid/wk_ready : schedule word stream          |
// |            done : one-cycle pulse after the last word transfers            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module aes_key_expander #(
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [0:255] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [0:31]  wk_out,
  output logic [5:0]   wk_idx,
  output logic         wk_valid,
  input  logic         wk_ready,
  output logic         done
);

  localparam int         c_NR           = NK + 6;
  localparam int         c_NW           = 4 * (c_NR + 1);
  localparam logic [2:0] c_MOD_LAST     = 3'(NK - 1);
  localparam logic [5:0] c_IDX_KEY_LAST = 6'(NK - 1);
  localparam logic [5:0] c_IDX_LAST     = 6'(c_NW - 1);

  localparam logic [1:0] c_ST_IDLE     = 2'd0;
  localparam logic [1:0] c_ST_EMIT_KEY = 2'd1;
  localparam logic [1:0] c_ST_EXPAND   = 2'd2;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  generate
    if (NK != 4 && NK != 6 && NK != 8) begin : g_nk_check
      $error("aes_key_expander: NK must be 4, 6 or 8");
    end
    if (NK < 8) begin : g_unused_key
      // Key bits beyond the selected key length are deliberately ignored.
      logic w_unused_key_bits;
      assign w_unused_key_bits = ^key_in[32*NK:255];
    end
  endgenerate

  function automatic logic [7:0] sbox(input logic [7:0] x);
    // 255 - x == ~x for an 8-bit index.
    return c_SBOX[{~x, 3'b000} +: 8];
  endfunction

  logic [1:0]  r_state;
  logic [31:0] r_win [0:NK-1];  // r_win[0] oldest, r_win[NK-1] newest
  logic [31:0] r_wk_out;
  logic [5:0]  r_wk_idx;
  logic        r_wk_valid;
  logic        r_done;
  logic [7:0]  r_rcon;
  logic [2:0]  r_mod;           // wk_idx mod NK of the word currently presented

  logic [2:0]  w_mod_next;
  logic [31:0] w_base;
  logic [31:0] w_prev;
  logic [31:0] w_sub_in;
  logic [31:0] w_sub;
  logic [31:0] w_temp;
  logic [31:0] w_next_word;
  logic [31:0] w_key_next;
  logic [7:0]  w_rcon_x;

  assign key_ready = (r_state == c_ST_IDLE);
  assign wk_out    = r_wk_out;
  assign wk_idx    = r_wk_idx;
  assign wk_valid  = r_wk_valid;
  assign done      = r_done;

  assign w_mod_next = (r_mod == c_MOD_LAST) ? 3'd0 : r_mod + 3'd1;
  assign w_rcon_x   = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  // The next word is computed from the window as it will look after the
  // current beat transfers. In EXPAND that window is shifted by one with the
  // presented word appended; on the last key beat the window is unchanged.
  // This lets the next word be registered on the transfer edge, giving one
  // word per cycle without a path from wk_ready to the outputs.
  assign w_base   = (r_state == c_ST_EXPAND) ? r_win[1]  : r_win[0];
  assign w_prev   = (r_state == c_ST_EXPAND) ? r_wk_out  : r_win[NK-1];
  assign w_sub_in = (w_mod_next == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign w_sub[8*b +: 8] = sbox(w_sub_in[8*b +: 8]);
  end

  always_comb begin
    w_temp = w_prev;
    if (w_mod_next == 3'd0) begin
      w_temp = w_sub ^ {r_rcon, 24'h0};
    end else if (NK == 8 && w_mod_next == 3'd4) begin
      w_temp = w_sub;
    end
  end

  assign w_next_word = w_base ^ w_temp;

  // Key word following the one presented during EMIT_KEY.
  always_comb begin
    w_key_next = r_win[0];
    for (int k = 1; k < NK; k++) begin
      if (r_mod == 3'(k - 1)) w_key_next = r_win[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_ST_IDLE;
      r_wk_out   <= '0;
      r_wk_idx   <= '0;
      r_wk_valid <= 1'b0;
      r_done     <= 1'b0;
      r_rcon     <= 8'h01;
      r_mod      <= '0;
      for (int k = 0; k < NK; k++) r_win[k] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (key_valid) begin
            for (int k = 0; k < NK; k++) r_win[k] <= key_in[32*k +: 32];
            r_wk_out   <= key_in[0 +: 32];
            r_wk_idx   <= '0;
            r_mod      <= '0;
            r_rcon     <= 8'h01;
            r_wk_valid <= 1'b1;
            r_state    <= c_ST_EMIT_KEY;
          end
        end
        c_ST_EMIT_KEY: begin
          if (wk_ready) begin
            r_wk_idx <= r_wk_idx + 6'd1;
            r_mod    <= w_mod_next;
            if (r_wk_idx == c_IDX_KEY_LAST) begin
              r_wk_out <= w_next_word;
              r_state  <= c_ST_EXPAND;
            end else begin
              r_wk_out <= w_key_next;
            end
          end
        end
        c_ST_EXPAND: begin
          if (wk_ready) begin
            for (int k = 0; k < NK - 1; k++) r_win[k] <= r_win[k+1];
            r_win[NK-1] <= r_wk_out;
            r_mod       <= w_mod_next;
            if (r_mod == 3'd0) r_rcon <= w_rcon_x;
            if (r_wk_idx == c_IDX_LAST) begin
              r_wk_valid <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= c_ST_IDLE;
            end else begin
              r_wk_idx <= r_wk_idx + 6'd1;
              r_wk_out <= w_next_word;
            end
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expander.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_aes_key_expander                                             |
// | Purpose  : Self-checking bench for aes_key_expander (NK = 4, 6, 8).        |
// |            Expected words come from an independent array-based key         |
// |            expansion with an S-box derived from GF(2^8) inversion.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_aes_key_expander;

  localparam logic [0:255] c_K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [0:255] c_K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [0:255] c_K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [0:255] kin [3];
  logic         kv  [3];
  logic         kr  [3];
  logic [0:31]  wo  [3];
  logic [5:0]   wi  [3];
  logic         wv  [3];
  logic         wr  [3];
  logic         dn  [3];

  aes_key_expander #(.NK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .key_in(kin[0]), .key_valid(kv[0]), .key_ready(kr[0]),
    .wk_out(wo[0]), .wk_idx(wi[0]), .wk_valid(wv[0]), .wk_ready(wr[0]), .done(dn[0]));
  aes_key_expander #(.NK(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .key_in(kin[1]), .key_valid(kv[1]), .key_ready(kr[1]),
    .wk_out(wo[1]), .wk_idx(wi[1]), .wk_valid(wv[1]), .wk_ready(wr[1]), .done(dn[1]));
  aes_key_expander #(.NK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .key_in(kin[2]), .key_valid(kv[2]), .key_ready(kr[2]),
    .wk_out(wo[2]), .wk_idx(wi[2]), .wk_valid(wv[2]), .wk_ready(wr[2]), .done(dn[2]));

  always #5 clk = ~clk;

  int          n_pass  = 0;
  int          n_fail  = 0;
  int          n_total = 0;
  int          act     = 0;
  int          xfers   = 0;
  int          dones [3] = '{0, 0, 0};
  int          nk_of [3] = '{4, 6, 8};
  int          nw_of [3] = '{44, 52, 60};
  logic        exp_done = 1'b0;
  logic [7:0]  sb [256];
  logic [37:0] q [$];        // {index, word}
  logic [37:0] mon_e;

  int          kat_n [8] = '{0, 0, 0, 1, 1, 2, 2, 2};
  int          kat_i [8] = '{0, 4, 43, 6, 51, 8, 12, 59};
  logic [31:0] kat_w [8] = '{32'h2b7e1516, 32'ha0fafe17, 32'hb6630ca6, 32'hfe0c91f7,
                             32'h01002202, 32'h9ba35411, 32'ha8b09c1a, 32'h706c631e};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));  // x^254 = x^-1, 0 -> 0
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  task automatic push_model(input int n, input logic [0:255] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int          nk = nk_of[n];
    int          nw = nw_of[n];
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < nw; i++) q.push_back({6'(i), w[i]});
  endtask

  // Scoreboard: any presented word must match the queue head; pop on transfer.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (dn[act] === 1'b1 || exp_done) begin
        chk("done pulse", 64'(dn[act]), 64'(exp_done));
        if (dn[act] === 1'b1) begin
          chk("key_ready at done", 64'(kr[act]), 64'd1);
          chk("beat count", 64'(xfers), 64'(nw_of[act]));
          dones[act]++;
          xfers = 0;
        end
      end
      exp_done = 1'b0;
      if (wv[act] === 1'b1) begin
        chk("key_ready while busy", 64'(kr[act]), 64'd0);
        chk("beat expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          mon_e = q[0];
          chk("wk_idx", 64'(wi[act]), 64'(mon_e[37:32]));
          chk("wk_out", 64'(wo[act]), 64'(mon_e[31:0]));
          if (wr[act] === 1'b1) begin
            void'(q.pop_front());
            xfers++;
            for (int k = 0; k < 8; k++) begin
              if (kat_n[k] == act && kat_i[k] == int'(mon_e[37:32]))
                chk("known-answer word", 64'(wo[act]), 64'(kat_w[k]));
            end
            if (int'(mon_e[37:32]) == nw_of[act] - 1) exp_done = 1'b1;
          end
        end
      end
    end
  end

  task automatic load(input int n, input logic [0:255] key);
    act = n;
    push_model(n, key);
    kin[n] = key;
    kv[n]  = 1'b1;
    @(posedge clk); #1;
    kv[n]  = 1'b0;
  endtask

  task automatic wait_done(input int n, input bit rnd, input int budget);
    int d0  = dones[n];
    int cyc = 0;
    while (dones[n] == d0 && cyc < budget) begin
      wr[n] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    chk("done within budget", 64'(dones[n] - d0), 64'd1);
  endtask

  initial begin
    int cyc;
    int d0;
    for (int n = 0; n < 3; n++) begin
      kin[n] = '0; kv[n] = 1'b0; wr[n] = 1'b0;
    end
    build_sbox();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int n = 0; n < 3; n++) begin
      chk("reset key_ready", 64'(kr[n]), 64'd1);
      chk("reset wk_valid",  64'(wv[n]), 64'd0);
      chk("reset wk_idx",    64'(wi[n]), 64'd0);
      chk("reset wk_out",    64'(wo[n]), 64'd0);
      chk("reset done",      64'(dn[n]), 64'd0);
    end

    // Full schedules with the consumer always ready.
    wr[0] = 1'b1; load(0, c_K128); wait_done(0, 1'b0, 200);
    wr[1] = 1'b1; load(1, c_K192); wait_done(1, 1'b0, 200);
    wr[2] = 1'b1; load(2, c_K256); wait_done(2, 1'b0, 200);

    // Random backpressure on the AES-128 schedule.
    wr[0] = 1'b0; load(0, c_K128); wait_done(0, 1'b1, 3000);

    // Abort mid-expansion with an asynchronous reset.
    wr[0] = 1'b1; load(0, c_K128);
    cyc = 0;
    while (wi[0] != 6'd20 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("reached index 20", 64'(wi[0]), 64'd20);
    d0 = dones[0];
    #2 rst_n = 1'b0;
    #1;
    chk("abort wk_valid",  64'(wv[0]), 64'd0);
    chk("abort wk_idx",    64'(wi[0]), 64'd0);
    chk("abort wk_out",    64'(wo[0]), 64'd0);
    chk("abort done",      64'(dn[0]), 64'd0);
    chk("abort key_ready", 64'(kr[0]), 64'd1);
    q.delete();
    exp_done = 1'b0;
    xfers    = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no done after abort", 64'(dones[0] - d0), 64'd0);
    chk("idle after abort",    64'(wv[0]), 64'd0);
    load(0, c_K128); wait_done(0, 1'b0, 200);

    // Back-to-back: key_valid held high, second load lands in the done cycle.
    act = 0;
    push_model(0, c_K128);
    push_model(0, c_K128);
    kin[0] = c_K128; kv[0] = 1'b1; wr[0] = 1'b1;
    cyc = 0;
    while (dn[0] !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("first done of back-to-back", 64'(dn[0]), 64'd1);
    @(posedge clk); #1;
    kv[0] = 1'b0;
    chk("restart wk_valid", 64'(wv[0]), 64'd1);
    chk("restart wk_idx",   64'(wi[0]), 64'd0);
    wait_done(0, 1'b0, 200);
    chk("queue drained", 64'(q.size()), 64'd0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
